sipo_frame_rx: RTL and testbench

Serial-to-parallel frame receiver sitting directly downstream of the serial left-shift (SISO) stage: it consumes that stage's one-bit-per-clock `dout` stream, detects framed words, and presents each assembled word on a parallel valid/ready output. It is the team's standard bridge from the serial shift path into word-wide logic.

---
 rtl/sipo_rx_pkg.sv | 15 +
 rtl/sipo_frame_rx_if.sv | 22 ++
 rtl/sipo_shift_in.sv | 20 ++
 rtl/sipo_frame_rx.sv | 133 +++++++++++++
 tb/tb_sipo_frame_rx.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/sipo_rx_pkg.sv
// Shared definitions for the serial-to-parallel frame receiver.
package sipo_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam int   DEF_DATA_W = 8;

endpackage

// File: rtl/sipo_frame_rx_if.sv
// Serial input plus word-wide valid/ready output and status pulses.
// master: the receiver; slave: the word consumer / serial source.
interface sipo_frame_rx_if #(parameter int DATA_W = 8);
  logic              din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              busy;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;

  modport master (
    input  din, dout_ready,
    output dout, dout_valid, busy, frame_err, parity_err, overrun
  );

  modport slave (
    output din, dout_ready,
    input  dout, dout_valid, busy, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/sipo_shift_in.sv
// DATA_W-bit shift-left register: new bit enters at the LSB.
module sipo_shift_in #(parameter int DATA_W = 8) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              shift_en_i,
  input  logic              din_i,
  output logic [DATA_W-1:0] q_o
);
  logic [DATA_W-1:0] sr_q;

  // Shift register with synchronous clear taking priority over shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             sr_q <= '0;
    else if (clr_i)      sr_q <= '0;
    else if (shift_en_i) sr_q <= {sr_q[DATA_W-2:0], din_i};
  end

  assign q_o = sr_q;
endmodule

// File: rtl/sipo_frame_rx.sv
// Framed serial receiver: start 1, DATA_W bits MSB first, [parity], stop 0.
// Optional even-parity bit enabled by defining SIPO_FRAME_RX_PARITY_EN.
module sipo_frame_rx import sipo_rx_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input logic             clk,
  input logic             rst,
  sipo_frame_rx_if.master bus
);
  localparam int CNT_W = $clog2(DATA_W);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] sr;
  logic              vld_q, vld_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              shift_en, sr_clr;
`ifdef SIPO_FRAME_RX_PARITY_EN
  logic              perr_q, perr_d;
`endif

  sipo_shift_in #(.DATA_W(DATA_W)) u_shift (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (sr_clr),
    .shift_en_i (shift_en),
    .din_i      (bus.din),
    .q_o        (sr)
  );

  // State, counter, output holding register and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef SIPO_FRAME_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state, word load and handshake; pulses default low every cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    vld_d    = vld_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    shift_en = 1'b0;
    sr_clr   = 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
    perr_d   = 1'b0;
`endif
    // Consumer takes the held word; a load below may override this.
    if (vld_q && bus.dout_ready) vld_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.din == START_BIT) begin
          sr_clr  = 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        shift_en = 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d = '0;
`ifdef SIPO_FRAME_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef SIPO_FRAME_RX_PARITY_EN
      ST_PARITY: begin
        // Even parity over data + parity bit; a bad frame skips the stop check.
        if (^{sr, bus.din}) begin
          perr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        state_d = ST_IDLE;
        if (bus.din == STOP_BIT) begin
          if (!vld_q || bus.dout_ready) begin
            dout_d = sr;
            vld_d  = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          ferr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = vld_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
`ifdef SIPO_FRAME_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx (DATA_W = 8).
module tb_sipo_frame_rx;
  import sipo_rx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  sipo_frame_rx_if #(.DATA_W(8)) bus ();

  sipo_frame_rx #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive one serial bit, let the edge happen, settle 1 time unit past it.
  task automatic tick(input logic b);
    bus.din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_data(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) tick(d[i]);
  endtask

  // Start + data [+ parity]; stop is driven by the caller.
  task automatic send_head(input logic [7:0] d, input logic par);
    tick(START_BIT);
    send_data(d);
`ifdef SIPO_FRAME_RX_PARITY_EN
    tick(par);
`else
    if (par) begin end
`endif
  endtask

  initial begin
    bus.din        = 1'b0;
    bus.dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout",  bus.dout,       0);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_busy",  bus.busy,       0);
    chk("rst_ferr",  bus.frame_err,  0);
    chk("rst_ovr",   bus.overrun,    0);
    chk("rst_perr",  bus.parity_err, 0);
    rst = 1'b0;
    tick(0); tick(0);
    chk("idle_busy", bus.busy, 0);

    // Basic frame 0xA5, ready high.
    tick(1);
    chk("busy_after_start", bus.busy, 1);
    send_data(8'hA5);
`ifdef SIPO_FRAME_RX_PARITY_EN
    tick(0);
`endif
    chk("busy_before_stop", bus.busy, 1);
    tick(0);
    chk("a5_dout",  bus.dout,       8'hA5);
    chk("a5_valid", bus.dout_valid, 1);
    chk("a5_busy",  bus.busy,       0);
    chk("a5_ferr",  bus.frame_err,  0);
    chk("a5_ovr",   bus.overrun,    0);
    tick(0);
    chk("a5_valid_one_cycle", bus.dout_valid, 0);

    // Stop bit 1: frame error, then clean 0x3C.
    send_head(8'hA5, 1'b0);
    tick(1);
    chk("ferr_pulse", bus.frame_err,  1);
    chk("ferr_valid", bus.dout_valid, 0);
    chk("ferr_busy",  bus.busy,       0);
    tick(0);
    chk("ferr_clear", bus.frame_err,  0);
    chk("ferr_idle",  bus.busy,       0);
    send_head(8'h3C, 1'b0);
    tick(0);
    chk("3c_dout",  bus.dout,       8'h3C);
    chk("3c_valid", bus.dout_valid, 1);
    tick(0);

    // Back-to-back with ready low: second frame overruns.
    bus.dout_ready = 1'b0;
    send_head(8'hA5, 1'b0);
    tick(0);
    chk("b2b_first_valid", bus.dout_valid, 1);
    send_head(8'h5A, 1'b0);
    tick(0);
    chk("ovr_pulse", bus.overrun,    1);
    chk("ovr_dout",  bus.dout,       8'hA5);
    chk("ovr_valid", bus.dout_valid, 1);
    tick(0);
    chk("ovr_clear", bus.overrun,    0);
    chk("ovr_hold",  bus.dout_valid, 1);
    bus.dout_ready = 1'b1;
    tick(0);
    chk("ready_clears_valid", bus.dout_valid, 0);

    // Ready raised on the edge the second frame completes.
    bus.dout_ready = 1'b0;
    send_head(8'hA5, 1'b0);
    tick(0);
    send_head(8'h5A, 1'b0);
    bus.dout_ready = 1'b1;
    tick(0);
    chk("swap_dout",  bus.dout,       8'h5A);
    chk("swap_valid", bus.dout_valid, 1);
    chk("swap_ovr",   bus.overrun,    0);
    tick(0);
    chk("swap_drain", bus.dout_valid, 0);

    // Reset mid-frame at data bit 4, then clean 0xFF.
    tick(1);
    send_data(8'h0F);  // complete 0x0F frame ahead of the aborted one
    tick(0);
    tick(1);
    tick(1); tick(0); tick(1); tick(0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_dout",  bus.dout,       0);
    chk("mid_rst_valid", bus.dout_valid, 0);
    chk("mid_rst_busy",  bus.busy,       0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(0);
    send_head(8'hFF, 1'b0);
    tick(0);
    chk("ff_dout",  bus.dout,       8'hFF);
    chk("ff_valid", bus.dout_valid, 1);
    tick(0);

`ifdef SIPO_FRAME_RX_PARITY_EN
    send_head(8'hA5, 1'b0);
    tick(0);
    chk("par_ok_dout",  bus.dout,       8'hA5);
    chk("par_ok_valid", bus.dout_valid, 1);
    tick(0);
    send_head(8'hA5, 1'b1);
    chk("perr_pulse", bus.parity_err, 1);
    chk("perr_valid", bus.dout_valid, 0);
    tick(0);
    chk("perr_clear", bus.parity_err, 0);
    chk("perr_noval", bus.dout_valid, 0);
    chk("perr_idle",  bus.busy,       0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
